// File: rtl/bram_arbiter2.sv
// -----------------------------------------------------------------------------
// bram_arbiter2
// Shares one single-port-per-direction block RAM (separate read/write address,
// byte write mask, one-cycle registered read) between two requesters A and B.
// At most one access is granted per cycle. Under contention the grant
// alternates between the two sides. Read data comes back one cycle after the
// grant and is tagged to the side that issued the read.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   a_req / b_req       access request (held with its payload until granted)
//   a_we  / b_we        1 = write, 0 = read
//   a_addr / b_addr     word address
//   a_wdata / b_wdata   write data
//   a_wmask / b_wmask   byte-lane write enables
//   a_gnt / b_gnt       request accepted this cycle (combinational)
//   a_rvalid / b_rvalid read data for that side is on rdata_out this cycle
//   rdata_out           shared read data, zero when neither rvalid is set
//   ram_raddr, ram_waddr, ram_wdata, ram_wmask, ram_wren  RAM drive
//   ram_rdata           RAM read data, valid one cycle after ram_raddr
// -----------------------------------------------------------------------------
module bram_arbiter2 #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [MASK_WIDTH-1:0] a_wmask,
    output logic                  a_gnt,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic [MASK_WIDTH-1:0] b_wmask,
    output logic                  b_gnt,
    output logic                  b_rvalid,

    output logic [DATA_WIDTH-1:0] rdata_out,

    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [MASK_WIDTH-1:0] ram_wmask,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0] req;
    logic [1:0] req_other;
    logic [1:0] we;
    logic [1:0] gnt;
    logic [1:0] rvalid;

    // prio: side that wins when both request (0 = A, 1 = B).
    logic prio_reg;
    logic prio_next;
    // Outstanding read issued last cycle and which side issued it.
    logic rd_pend_reg;
    logic rd_pend_next;
    logic rd_src_reg;
    logic rd_src_next;

    // Payload of the granted side.
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MASK_WIDTH-1:0] sel_wmask;

    assign req       = {b_req, a_req};
    assign req_other = {a_req, b_req};
    assign we        = {b_we, a_we};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            localparam logic SIDE = (gi == 1);
            // A side wins if it is alone, or if both request and prio names it.
            assign gnt[gi]    = !reset && req[gi] && (!req_other[gi] || (prio_reg == SIDE));
            // Responses still in flight when reset arrives are suppressed here;
            // the tag itself is cleared at the reset edge.
            assign rvalid[gi] = !reset && rd_pend_reg && (rd_src_reg == SIDE);
        end
    endgenerate

    assign a_gnt    = gnt[0];
    assign b_gnt    = gnt[1];
    assign a_rvalid = rvalid[0];
    assign b_rvalid = rvalid[1];

    assign rdata_out = (|rvalid) ? ram_rdata : '0;

    // Payload mux: B's fields only when B holds the grant.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        sel_wmask = a_wmask;
        if (gnt[1]) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_wmask = b_wmask;
        end
    end

    // RAM drive in the grant cycle; everything idles at zero otherwise.
    always_comb begin
        ram_raddr = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        ram_wren  = 1'b0;
        if (|gnt) begin
            if (sel_we) begin
                ram_waddr = sel_addr;
                ram_wdata = sel_wdata;
                ram_wmask = sel_wmask;
                ram_wren  = 1'b1;
            end else begin
                ram_raddr = sel_addr;
            end
        end
    end

    always_comb begin
        prio_next = prio_reg;
        // After any grant the other side gets priority next time.
        if (gnt[0]) begin
            prio_next = 1'b1;
        end else if (gnt[1]) begin
            prio_next = 1'b0;
        end
        rd_pend_next = |(gnt & ~we);
        rd_src_next  = gnt[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_reg    <= 1'b0;
            rd_pend_reg <= 1'b0;
            rd_src_reg  <= 1'b0;
        end else begin
            prio_reg    <= prio_next;
            rd_pend_reg <= rd_pend_next;
            rd_src_reg  <= rd_src_next;
        end
    end

endmodule
